// File: rtl/speech_pkg.sv
//------------------------------------------------------------------------------
// speech_pkg : shared types and defaults for the speech sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package speech_pkg;

    localparam int DEF_NUM_SLOTS = 4;
    localparam int DEF_TMO_W     = 24;

    typedef logic [1:0] slot_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REC   = 3'd1,
        FFT   = 3'd2,
        STORE = 3'd3,
        CMP   = 3'd4
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/speech_seq_wdog.sv
//------------------------------------------------------------------------------
// speech_seq_wdog : per-phase watchdog counter, saturates at all-ones
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module speech_seq_wdog
    import speech_pkg::*;
#(
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clr,
    input  logic en,
    output logic sat
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !sat) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    assign sat = &r_cnt;

endmodule

`default_nettype wire

// File: rtl/speech_seq.sv
//------------------------------------------------------------------------------
// speech_seq : record -> FFT -> store/compare sequencer for voice control.
// Optional watchdog enabled by defining SPEECH_SEQ_TIMEOUT_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module speech_seq
    import speech_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int SLOT_W    = 2,
    parameter int TMO_W     = DEF_TMO_W
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              record,
    input  logic              sample,
    output logic              rec_en,
    input  logic              rec_done,
    output logic              fft_start,
    input  logic              fft_done,
    output logic              fft_dst_tpl,
    output logic [SLOT_W-1:0] slot,
    output logic              cmp_start,
    input  logic              cmp_done,
    input  logic              cmp_hit,
    output slot_t             match,
    output logic              match_valid,
    output logic              no_match,
    output logic              busy,
    output logic              err
);

    localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(NUM_SLOTS - 1);

    if (NUM_SLOTS < 1 || NUM_SLOTS > 4 || (1 << SLOT_W) < NUM_SLOTS || TMO_W < 2) begin : g_param_chk
        $error("speech_seq: illegal NUM_SLOTS/SLOT_W/TMO_W combination");
    end

    seq_state_t        r_state;
    logic [SLOT_W-1:0] r_tpl_ptr;
    logic              r_mode;
    logic              w_wd_sat;

`ifdef SPEECH_SEQ_TIMEOUT_EN
    seq_state_t r_state_q;
    logic       w_wd_clr;
    logic       w_wd_en;

    // Any state change restarts the watchdog window.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= r_state;
        end
    end

    assign w_wd_clr = (r_state != r_state_q);
    assign w_wd_en  = (r_state == REC) || (r_state == FFT) || (r_state == CMP);

    speech_seq_wdog #(
        .TMO_W (TMO_W)
    ) u_wdog (
        .clk     (clk),
        .reset_L (reset_L),
        .clr     (w_wd_clr),
        .en      (w_wd_en),
        .sat     (w_wd_sat)
    );
`else
    assign w_wd_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= IDLE;
            r_tpl_ptr   <= '0;
            r_mode      <= 1'b0;
            rec_en      <= 1'b0;
            fft_start   <= 1'b0;
            fft_dst_tpl <= 1'b0;
            slot        <= '0;
            cmp_start   <= 1'b0;
            match       <= '0;
            match_valid <= 1'b0;
            no_match    <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            fft_start   <= 1'b0;
            cmp_start   <= 1'b0;
            match_valid <= 1'b0;
            no_match    <= 1'b0;

            if (w_wd_sat && (r_state inside {REC, FFT, CMP})) begin
                err     <= 1'b1;
                rec_en  <= 1'b0;
                busy    <= 1'b0;
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (record) begin
                            r_mode      <= sample;
                            err         <= 1'b0;
                            rec_en      <= 1'b1;
                            busy        <= 1'b1;
                            fft_dst_tpl <= sample;
                            slot        <= sample ? r_tpl_ptr : '0;
                            r_state     <= REC;
                        end
                    end
                    REC: begin
                        if (rec_done) begin
                            rec_en    <= 1'b0;
                            fft_start <= 1'b1;
                            r_state   <= FFT;
                        end
                    end
                    FFT: begin
                        if (fft_done) begin
                            if (r_mode) begin
                                r_state <= STORE;
                            end else begin
                                slot      <= '0;
                                cmp_start <= 1'b1;
                                r_state   <= CMP;
                            end
                        end
                    end
                    STORE: begin
                        r_tpl_ptr <= (r_tpl_ptr == c_last_slot) ? '0 : r_tpl_ptr + SLOT_W'(1);
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                    CMP: begin
                        // Slots are walked upward, so the lowest hitting index wins.
                        if (cmp_done) begin
                            if (cmp_hit) begin
                                match       <= slot_t'(slot);
                                match_valid <= 1'b1;
                                busy        <= 1'b0;
                                r_state     <= IDLE;
                            end else if (slot != c_last_slot) begin
                                slot      <= slot + SLOT_W'(1);
                                cmp_start <= 1'b1;
                            end else begin
                                no_match <= 1'b1;
                                busy     <= 1'b0;
                                r_state  <= IDLE;
                            end
                        end
                    end
                    default: begin
                        rec_en  <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_speech_seq.sv
//------------------------------------------------------------------------------
// tb_speech_seq : scoreboard bench for the speech sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_speech_seq;
    import speech_pkg::*;

    localparam int NS = 4;
    localparam int SW = 2;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          record = 1'b0;
    logic          sample = 1'b0;
    logic          rec_done = 1'b0;
    logic          fft_done = 1'b0;
    logic          cmp_done = 1'b0;
    logic          cmp_hit = 1'b0;
    logic          rec_en, fft_start, fft_dst_tpl, cmp_start;
    logic          match_valid, no_match, busy, err;
    logic [SW-1:0] slot;
    slot_t         match;

    int vectors = 0;
    int miscompares = 0;
    int q_slot[$];
    int q_res[$];
    int exp_tpl = 0;
    int exp_match = 0;

    int obs_slots[$];
    int obs_mv, obs_nm, obs_match;
    bit cmp_to;

    always #5 clk = ~clk;

    speech_seq #(
        .NUM_SLOTS (NS),
        .SLOT_W    (SW),
        .TMO_W     (TW)
    ) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .record      (record),
        .sample      (sample),
        .rec_en      (rec_en),
        .rec_done    (rec_done),
        .fft_start   (fft_start),
        .fft_done    (fft_done),
        .fft_dst_tpl (fft_dst_tpl),
        .slot        (slot),
        .cmp_start   (cmp_start),
        .cmp_done    (cmp_done),
        .cmp_hit     (cmp_hit),
        .match       (match),
        .match_valid (match_valid),
        .no_match    (no_match),
        .busy        (busy),
        .err         (err)
    );

    function automatic logic [11:0] out_vec();
        return {rec_en, fft_start, fft_dst_tpl, slot, cmp_start, match,
                match_valid, no_match, busy, err};
    endfunction

    // Press, record phase and FFT phase; returns on the edge after fft_done.
    task automatic run_front(input bit s, input int rec_len, input int fft_len, input bit inject,
                             output int rec_cycles, output int fft_starts,
                             output int slot_seen, output int dst_seen);
        rec_cycles = 0;
        fft_starts = 0;
        slot_seen  = -1;
        dst_seen   = -1;
        @(negedge clk);
        record   = 1'b1;
        sample   = s;
        rec_done = inject;
        for (int i = 1; i <= rec_len; i++) begin
            @(negedge clk);
            if (i == 1) begin
                slot_seen = int'(slot);
                dst_seen  = int'(fft_dst_tpl);
                sample    = ~s;
            end
            if (rec_en) rec_cycles++;
            if (fft_start) fft_starts++;
            record   = inject && (i == 3);
            fft_done = inject && (i == 2);
            rec_done = (i == rec_len);
        end
        for (int j = 1; j <= fft_len; j++) begin
            @(negedge clk);
            if (rec_en) rec_cycles++;
            if (fft_start) fft_starts++;
            record   = inject && (j == 2);
            rec_done = inject && (j == 3);
            fft_done = (j == fft_len);
        end
        @(negedge clk);
        fft_done = 1'b0;
        record   = 1'b0;
        rec_done = 1'b0;
        if (rec_en) rec_cycles++;
        if (fft_start) fft_starts++;
    endtask

    // Comparator model: answers each cmp_start after a few cycles with hits[k].
    task automatic run_cmp(input logic [3:0] hits);
        int k;
        int cd;
        k = 0;
        cd = -1;
        obs_slots.delete();
        obs_mv = 0;
        obs_nm = 0;
        obs_match = -1;
        cmp_to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (cmp_start) begin
                obs_slots.push_back(int'(slot));
                cd = 3;
            end
            if (match_valid) begin obs_mv++; obs_match = int'(match); end
            if (no_match) begin obs_nm++; obs_match = int'(match); end
            cmp_done = 1'b0;
            cmp_hit  = 1'b0;
            if (cd == 0) begin
                cmp_done = 1'b1;
                cmp_hit  = (k < 4) ? hits[k] : 1'b0;
                k++;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (!busy && !cmp_done && (obs_mv + obs_nm) > 0) begin
                cmp_to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        cmp_done = 1'b0;
        cmp_hit  = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (out_vec() !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_during: got %h expected %h", out_vec(), 12'h000);
        end
        @(negedge clk);
        reset_L = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_vec() !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", out_vec(), 12'h000);
        end
    endtask

    task automatic test_sample_capture();
        int rc, fs, ss, ds, e;
        q_slot.push_back(exp_tpl);
        run_front(1'b1, 1025, 50, 1'b0, rc, fs, ss, ds);
        e = q_slot.pop_front();
        vectors++;
        if (rc !== 1025) begin miscompares++; $display("FAIL cap_rec_en_cycles: got %0d expected %0d", rc, 1025); end
        vectors++;
        if (fs !== 1) begin miscompares++; $display("FAIL cap_fft_starts: got %0d expected %0d", fs, 1); end
        vectors++;
        if (ds !== 1) begin miscompares++; $display("FAIL cap_dst_tpl: got %0d expected %0d", ds, 1); end
        vectors++;
        if (ss !== e) begin miscompares++; $display("FAIL cap_slot: got %0d expected %0d", ss, e); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL cap_busy_store: got %b expected %b", busy, 1'b1); end
        @(negedge clk);
        vectors++;
        if ({busy, match_valid, no_match, rec_en} !== 4'b0000) begin
            miscompares++;
            $display("FAIL cap_idle_after: got %b expected %b", {busy, match_valid, no_match, rec_en}, 4'b0000);
        end
        exp_tpl = (exp_tpl + 1) % NS;
    endtask

    task automatic test_real_hit();
        int rc, fs, ss, ds, e, o;
        for (int i = 0; i < 3; i++) q_slot.push_back(i);
        q_res.push_back(2);
        run_front(1'b0, 20, 10, 1'b0, rc, fs, ss, ds);
        vectors++;
        if (ds !== 0) begin miscompares++; $display("FAIL hit_dst_tpl: got %0d expected %0d", ds, 0); end
        vectors++;
        if (fs !== 1) begin miscompares++; $display("FAIL hit_fft_starts: got %0d expected %0d", fs, 1); end
        run_cmp(4'b0100);
        vectors++;
        if (cmp_to !== 1'b0) begin miscompares++; $display("FAIL hit_timeout: got %b expected %b", cmp_to, 1'b0); end
        vectors++;
        if (obs_slots.size() !== 3) begin miscompares++; $display("FAIL hit_cmp_starts: got %0d expected %0d", obs_slots.size(), 3); end
        while (q_slot.size() > 0) begin
            e = q_slot.pop_front();
            o = (obs_slots.size() > 0) ? obs_slots.pop_front() : -1;
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL hit_cmp_slot: got %0d expected %0d", o, e); end
        end
        e = q_res.pop_front();
        o = (obs_nm > 0) ? -1 : obs_match;
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL hit_match: got %0d expected %0d", o, e); end
        vectors++;
        if (obs_mv !== 1) begin miscompares++; $display("FAIL hit_match_valid_count: got %0d expected %0d", obs_mv, 1); end
        exp_match = 2;
    endtask

    task automatic test_real_miss();
        int rc, fs, ss, ds, e, o;
        for (int i = 0; i < NS; i++) q_slot.push_back(i);
        q_res.push_back(-1);
        run_front(1'b0, 12, 6, 1'b1, rc, fs, ss, ds);
        run_cmp(4'b0000);
        vectors++;
        if (cmp_to !== 1'b0) begin miscompares++; $display("FAIL miss_timeout: got %b expected %b", cmp_to, 1'b0); end
        vectors++;
        if (obs_slots.size() !== NS) begin miscompares++; $display("FAIL miss_cmp_starts: got %0d expected %0d", obs_slots.size(), NS); end
        while (q_slot.size() > 0) begin
            e = q_slot.pop_front();
            o = (obs_slots.size() > 0) ? obs_slots.pop_front() : -1;
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL miss_cmp_slot: got %0d expected %0d", o, e); end
        end
        e = q_res.pop_front();
        o = (obs_nm == 1 && obs_mv == 0) ? -1 : obs_match;
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL miss_result: got %0d expected %0d", o, e); end
        vectors++;
        if (int'(match) !== exp_match) begin miscompares++; $display("FAIL miss_match_held: got %0d expected %0d", match, exp_match); end
    endtask

    task automatic test_slot_wrap();
        int rc, fs, ss, ds, e;
        for (int n = 0; n < 5; n++) begin
            q_slot.push_back(exp_tpl);
            run_front(1'b1, 8, 5, 1'b1, rc, fs, ss, ds);
            e = q_slot.pop_front();
            vectors++;
            if (ss !== e) begin miscompares++; $display("FAIL wrap_slot[%0d]: got %0d expected %0d", n, ss, e); end
            vectors++;
            if (rc !== 8) begin miscompares++; $display("FAIL wrap_rec_en_cycles[%0d]: got %0d expected %0d", n, rc, 8); end
            vectors++;
            if (fs !== 1) begin miscompares++; $display("FAIL wrap_fft_starts[%0d]: got %0d expected %0d", n, fs, 1); end
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin miscompares++; $display("FAIL wrap_busy_end[%0d]: got %b expected %b", n, busy, 1'b0); end
            exp_tpl = (exp_tpl + 1) % NS;
        end
    endtask

    task automatic test_reset_mid();
        int rc, fs, ss, ds, e;
        run_front(1'b0, 10, 5, 1'b0, rc, fs, ss, ds);
        cmp_done = 1'b1;
        cmp_hit  = 1'b0;
        @(negedge clk);
        cmp_done = 1'b0;
        vectors++;
        if ({cmp_start, slot} !== {1'b1, 2'd1}) begin
            miscompares++;
            $display("FAIL rstmid_slot1: got %b expected %b", {cmp_start, slot}, {1'b1, 2'd1});
        end
        #2 reset_L = 1'b0;
        #1;
        vectors++;
        if (out_vec() !== 12'h000) begin miscompares++; $display("FAIL rstmid_async: got %h expected %h", out_vec(), 12'h000); end
        @(negedge clk);
        #2 reset_L = 1'b1;
        exp_tpl = 0;
        exp_match = 0;
        q_slot.push_back(exp_tpl);
        run_front(1'b1, 8, 5, 1'b0, rc, fs, ss, ds);
        e = q_slot.pop_front();
        vectors++;
        if (ss !== e) begin miscompares++; $display("FAIL rstmid_clean_slot: got %0d expected %0d", ss, e); end
        vectors++;
        if (rc !== 8) begin miscompares++; $display("FAIL rstmid_clean_rec: got %0d expected %0d", rc, 8); end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_clean_idle: got %b expected %b", busy, 1'b0); end
        exp_tpl = (exp_tpl + 1) % NS;
    endtask

`ifdef SPEECH_SEQ_TIMEOUT_EN
    task automatic test_watchdog();
        int cnt;
        @(negedge clk);
        record = 1'b1;
        sample = 1'b1;
        @(negedge clk);
        record = 1'b0;
        repeat (4) @(negedge clk);
        rec_done = 1'b1;
        @(negedge clk);
        rec_done = 1'b0;
        cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            cnt++;
            if (!busy) break;
        end
        vectors++;
        if (cnt < 255 || cnt > 258) begin miscompares++; $display("FAIL wdog_cycles: got %0d expected 255..258", cnt); end
        vectors++;
        if ({err, busy, rec_en} !== 3'b100) begin
            miscompares++;
            $display("FAIL wdog_state: got %b expected %b", {err, busy, rec_en}, 3'b100);
        end
        record = 1'b1;
        @(negedge clk);
        record = 1'b0;
        vectors++;
        if ({err, busy} !== 2'b01) begin miscompares++; $display("FAIL wdog_clear: got %b expected %b", {err, busy}, 2'b01); end
        repeat (3) @(negedge clk);
        rec_done = 1'b1;
        @(negedge clk);
        rec_done = 1'b0;
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({err, busy} !== 2'b00) begin miscompares++; $display("FAIL wdog_recover: got %b expected %b", {err, busy}, 2'b00); end
    endtask
`else
    task automatic test_err_tied();
        int hi;
        hi = 0;
        @(negedge clk);
        record = 1'b1;
        sample = 1'b0;
        @(negedge clk);
        record = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (err) hi++;
        end
        vectors++;
        if (hi !== 0) begin miscompares++; $display("FAIL err_tied: got %0d err cycles expected %0d", hi, 0); end
        vectors++;
        if ({busy, rec_en} !== 2'b11) begin miscompares++; $display("FAIL no_wdog_wait: got %b expected %b", {busy, rec_en}, 2'b11); end
    endtask
`endif

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sample_capture();
        test_real_hit();
        test_real_miss();
        test_slot_wrap();
        test_reset_mid();
`ifdef SPEECH_SEQ_TIMEOUT_EN
        test_watchdog();
`else
        test_err_tied();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
